// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction fetch stage. Keeps the next fetch PC and has at most one
//   request outstanding to instruction memory (req held until a single-cycle
//   ack). The returned word and its PC go into a valid-qualified output slot
//   for decode. A one-entry skid buffer catches a word that returns while the
//   slot is blocked by stall. A redirect flushes the slot and restarts fetch
//   at the new PC.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | just out of reset, no request yet
//   FETCH | request to addr_q outstanding; returned word is kept
//   FLUSH | request outstanding but stale (redirected); returned word dropped
//   HOLD  | no request; returned word parked in skid_q until slot frees
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   stall_i           decode cannot accept the slot this cycle
//   redirect_i        control-flow change, redirect_pc_i is the new PC
//   redirect_pc_i     new PC, bits [1:0] ignored
//   imem_req_o/addr_o request to instruction memory, addr stable while req
//   imem_ack_i/data_i single-cycle response carrying the word
//   ins_o/pc_o        slot contents to decode (ins_o = NOP_INS when invalid)
//   ins_valid_o       slot valid; consumed when ins_valid_o & ~stall_i
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] ins_o,
    output logic [31:0] pc_o,
    output logic        ins_valid_o
);

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH, HOLD} state_t;

    state_t      state_q, state_n;
    logic [31:0] pc_q, pc_n;
    logic [31:0] addr_q, addr_n;
    logic [31:0] skid_q, skid_n;
    logic [31:0] ins_q, ins_n;
    logic [31:0] pco_q, pco_n;
    logic        req_q, req_n;
    logic        valid_q, valid_n;

    logic        slot_free;
    logic [31:0] redir_pc;
    logic [31:0] addr_inc;

    assign slot_free = ~valid_q | ~stall_i;
    assign redir_pc  = {redirect_pc_i[31:2], 2'b00};
    assign addr_inc  = addr_q + 32'd4;

    assign imem_req_o  = req_q;
    assign imem_addr_o = addr_q;
    assign ins_o       = ins_q;
    assign pc_o        = pco_q;
    assign ins_valid_o = valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            skid_q  <= 32'd0;
            ins_q   <= NOP_INS;
            pco_q   <= 32'd0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            addr_q  <= addr_n;
            skid_q  <= skid_n;
            ins_q   <= ins_n;
            pco_q   <= pco_n;
            req_q   <= req_n;
            valid_q <= valid_n;
        end
    end

    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        addr_n  = addr_q;
        skid_n  = skid_q;
        ins_n   = ins_q;
        pco_n   = pco_q;
        req_n   = req_q;
        valid_n = valid_q;

        case (state_q)
            IDLE: begin
                state_n = FETCH;
                req_n   = 1'b1;
                if (redirect_i) begin
                    valid_n = 1'b0;
                    pc_n    = redir_pc;
                    addr_n  = redir_pc;
                end else begin
                    addr_n = pc_q;
                end
            end
            FETCH: begin
                if (redirect_i) begin
                    valid_n = 1'b0;
                    pc_n    = redir_pc;
                    if (imem_ack_i) begin
                        addr_n = redir_pc;
                    end else begin
                        // request still in flight; its answer must be dropped
                        state_n = FLUSH;
                    end
                end else if (imem_ack_i && slot_free) begin
                    ins_n   = imem_data_i;
                    pco_n   = addr_q;
                    valid_n = 1'b1;
                    pc_n    = addr_inc;
                    addr_n  = addr_inc;
                end else if (imem_ack_i) begin
                    skid_n  = imem_data_i;
                    req_n   = 1'b0;
                    state_n = HOLD;
                end else if (valid_q && !stall_i) begin
                    valid_n = 1'b0;
                end
            end
            FLUSH: begin
                if (redirect_i) begin
                    valid_n = 1'b0;
                    pc_n    = redir_pc;
                end
                if (imem_ack_i) begin
                    state_n = FETCH;
                    addr_n  = redirect_i ? redir_pc : pc_q;
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    valid_n = 1'b0;
                    pc_n    = redir_pc;
                    addr_n  = redir_pc;
                    req_n   = 1'b1;
                    state_n = FETCH;
                end else if (!stall_i) begin
                    ins_n   = skid_q;
                    pco_n   = addr_q;
                    valid_n = 1'b1;
                    pc_n    = addr_inc;
                    addr_n  = addr_inc;
                    req_n   = 1'b1;
                    state_n = FETCH;
                end
            end
            default: begin
                state_n = IDLE;
                req_n   = 1'b0;
                valid_n = 1'b0;
            end
        endcase

        // an empty slot always presents a NOP to decode
        if (!valid_n) begin
            ins_n = NOP_INS;
        end
    end

endmodule
